// File: rtl/ga_pkg.sv
// Shared GA definitions: evaluation-scheduler state encoding and fitness/chromosome widths.
package ga_pkg;

  localparam int          NUM_CHROM_OUTPUTS = 8;
  localparam int          FITNESS_W         = 32;
  localparam int          CHROM_BITS        = 992;
  localparam logic [31:0] FITNESS_MAX       = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LOAD      = 4'd2,
    ST_ARM       = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_SUM       = 4'd5,
    ST_WRITE     = 4'd6,
    ST_ACK       = 4'd7,
    ST_NEXT      = 4'd8,
    ST_DONE      = 4'd9
  } sched_state_t;

endpackage

// File: rtl/error_sum_reducer.sv
// Reduces the per-output error sums to a single fitness word, saturating at FITNESS_MAX.
module error_sum_reducer
  import ga_pkg::*;
(
  input  logic [NUM_CHROM_OUTPUTS-1:0][FITNESS_W-1:0] i_sums,
  output logic [FITNESS_W-1:0]                        o_sum
);

  // 35 bits hold the sum of eight 32-bit words without overflow.
  logic [34:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int unsigned k = 0; k < NUM_CHROM_OUTPUTS; k++) begin
      w_acc = w_acc + 35'(i_sums[k]);
    end
    o_sum = (w_acc[34:32] != 3'd0) ? FITNESS_MAX : w_acc[31:0];
  end

endmodule

// File: rtl/population_evaluation_scheduler.sv
// Walks one chromosome processor across the population, writing fitness and tracking the best individual.
module population_evaluation_scheduler
  import ga_pkg::*;
#(
  parameter int POP_SIZE   = 16,
  parameter int IDX_W      = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1,
  parameter int CHROM_BITS = ga_pkg::CHROM_BITS
) (
  input  logic                                        iClock,
  input  logic                                        iReset_n,
  input  logic                                        iStartGeneration,
  input  logic                                        iStopOnPerfect,
  output logic                                        oBusy,
  output logic                                        oGenerationDone,
  output logic [IDX_W-1:0]                            oChromIndex,
  input  logic [CHROM_BITS-1:0]                       iChromData,
  output logic [CHROM_BITS-1:0]                       oChromDescription,
  input  logic                                        iProcReady,
  output logic                                        oStartProcessing,
  input  logic                                        iProcDone,
  output logic                                        oDoneFeedback,
  input  logic [NUM_CHROM_OUTPUTS-1:0][FITNESS_W-1:0] iErrorSums,
  output logic                                        oFitnessWe,
  output logic [IDX_W-1:0]                            oFitnessAddr,
  output logic [FITNESS_W-1:0]                        oFitnessData,
  output logic [IDX_W-1:0]                            oBestIndex,
  output logic [FITNESS_W-1:0]                        oBestFitness,
  output logic                                        oPerfectFound,
  output logic [IDX_W:0]                              oEvalCount
);

  sched_state_t          r_state;
  logic [IDX_W-1:0]      r_index;
  logic [CHROM_BITS-1:0] r_desc;
  logic [FITNESS_W-1:0]  r_fitness;
  logic [FITNESS_W-1:0]  r_bestFit;
  logic [IDX_W-1:0]      r_bestIdx;
  logic                  r_perfect;
  logic [IDX_W:0]        r_evalCount;
  logic [FITNESS_W-1:0]  w_sum;
  logic                  w_lastIdx;

  error_sum_reducer u_reducer (
    .i_sums (iErrorSums),
    .o_sum  (w_sum)
  );

  assign w_lastIdx = (r_index == IDX_W'(POP_SIZE - 1));

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_desc      <= '0;
      r_fitness   <= '0;
      r_bestFit   <= FITNESS_MAX;
      r_bestIdx   <= '0;
      r_perfect   <= 1'b0;
      r_evalCount <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStartGeneration) begin
            r_index     <= '0;
            r_bestFit   <= FITNESS_MAX;
            r_bestIdx   <= '0;
            r_perfect   <= 1'b0;
            r_evalCount <= '0;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_desc  <= iChromData;
          r_state <= ST_ARM;
        end
        ST_ARM:       if (iProcReady) r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (iProcDone)  r_state <= ST_SUM;
        ST_SUM: begin
          r_fitness <= w_sum;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          // Strict compare keeps the earlier (lower) index on ties.
          if (r_fitness < r_bestFit) begin
            r_bestFit <= r_fitness;
            r_bestIdx <= r_index;
          end
          if (r_fitness == '0) r_perfect <= 1'b1;
          r_evalCount <= r_evalCount + 1'b1;
          r_state     <= ST_ACK;
        end
        ST_ACK: if (!iProcDone) r_state <= ST_NEXT;
        ST_NEXT: begin
          if (w_lastIdx || (iStopOnPerfect && r_perfect)) begin
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A DONE seen while arming is stale from before a reset; feedback drains it.
  assign oDoneFeedback     = (r_state == ST_ACK) || ((r_state == ST_ARM) && iProcDone);
  assign oStartProcessing  = (r_state == ST_ARM);
  assign oBusy             = (r_state != ST_IDLE);
  assign oGenerationDone   = (r_state == ST_DONE);
  assign oFitnessWe        = (r_state == ST_WRITE);
  assign oChromIndex       = r_index;
  assign oChromDescription = r_desc;
  assign oFitnessAddr      = r_index;
  assign oFitnessData      = r_fitness;
  assign oBestIndex        = r_bestIdx;
  assign oBestFitness      = r_bestFit;
  assign oPerfectFound     = r_perfect;
  assign oEvalCount        = r_evalCount;

endmodule

// File: doc/population_evaluation_scheduler.md
# population_evaluation_scheduler

Sequences one `chromosomeProcessingStateMachine` instance across a whole population. For each chromosome it:
- fetches the description from the population RAM,
- presents the description to the processor and starts it,
- waits for completion and reduces the eight per-output error sums to one fitness word,
- writes the fitness back and acknowledges the processor.

It tracks the best (lowest-error) individual of the generation and sits between the GA top-level controller and the evaluation datapath.

## Interface
Parameters:
- POP_SIZE, 16: chromosomes per generation (≥1).
- IDX_W, $clog2(POP_SIZE) (min 1): index width.
- CHROM_BITS, 992: chromosome description width.

Ports:
- iClock  in  1  single clock; all logic on rising edge.
- iReset_n  in  1  reset; asynchronous assert, active-low.
- iStartGeneration  in  1  start pulse; sampled only in IDLE.
- iStopOnPerfect  in  1  end generation early once a fitness of 0 is written.
- oBusy  out  1  high in every state except IDLE.
- oGenerationDone  out  1  one-cycle pulse at generation end.
- oChromIndex  out  IDX_W  population RAM read address.
- iChromData  in  CHROM_BITS  RAM read data, valid one cycle after oChromIndex.
- oChromDescription  out  CHROM_BITS  registered description driven to the processor.
- iProcReady  in  1  processor oReadyToProcess.
- oStartProcessing  out  1  processor iStartProcessing.
- iProcDone  in  1  processor oDoneProcessing.
- oDoneFeedback  out  1  processor iDoneProcessingFeedback.
- iErrorSums  in  8×32  processor oErrorSums.
- oFitnessWe  out  1  fitness RAM write strobe.
- oFitnessAddr  out  IDX_W  fitness RAM address.
- oFitnessData  out  32  fitness value.
- oBestIndex  out  IDX_W  index of the lowest fitness so far.
- oBestFitness  out  32  lowest fitness so far.
- oPerfectFound  out  1  set when any fitness of 0 has been written this generation.
- oEvalCount  out  IDX_W+1  chromosomes completed this generation.

## Operation
States: IDLE, FETCH, LOAD, ARM, WAIT_DONE, SUM, WRITE, ACK, NEXT, DONE.
- IDLE:
  - On iStartGeneration: index←0, oBestFitness←32'hFFFFFFFF, oBestIndex←0, oPerfectFound←0, oEvalCount←0; go to FETCH.
  - iStartGeneration in any other state is ignored.
- FETCH: oChromIndex=index; one RAM-latency cycle; go to LOAD.
- LOAD: oChromDescription←iChromData; go to ARM.
- ARM:
  - oStartProcessing=1 (combinational from state).
  - Leaves to WAIT_DONE on the first cycle with iProcReady=1.
  - If iProcDone=1 while in ARM (stale DONE left over from before a reset), oDoneFeedback=1 in that cycle to drain the processor back to IDLE.
- WAIT_DONE: wait for iProcDone=1; go to SUM.
- SUM:
  - fitness←Σ iErrorSums[0..7], using a 35-bit internal sum.
  - Saturate to 32'hFFFFFFFF if the sum exceeds 32 bits.
  - Go to WRITE.
- WRITE:
  - oFitnessWe=1 for exactly one cycle, oFitnessAddr=index, oFitnessData=fitness.
  - If fitness < oBestFitness (strict), update oBestFitness and oBestIndex. On ties the lower index is kept.
  - If fitness==0, oPerfectFound←1.
  - oEvalCount+1.
  - Go to ACK.
- ACK: oDoneFeedback=1 until iProcDone is sampled 0; then go to NEXT.
- NEXT:
  - If index==POP_SIZE-1, or (iStopOnPerfect && oPerfectFound): go to DONE.
  - Otherwise index+1 and go to FETCH. index never wraps.
- DONE: oGenerationDone=1 for one cycle; go to IDLE. The best/perfect/count outputs hold until the next start.
- oChromDescription stays stable from LOAD until the next LOAD, including while the processor runs.

## Timing
- Reset values: state IDLE, all strobes 0, oChromIndex 0, oChromDescription 0, oFitnessAddr/oFitnessData 0, oBestIndex 0, oBestFitness 32'hFFFFFFFF, oPerfectFound 0, oEvalCount 0.
- Reset mid-generation aborts immediately; the processor is not reset. The first ARM after restart handles a stale DONE as described in Operation.
- Start latency: iStartGeneration sampled at edge 0 → oStartProcessing high in cycle 3 (FETCH 1, LOAD 2, ARM 3), given iProcReady=1.
- Overhead from the iProcDone edge to the next oStartProcessing: SUM, WRITE, ACK (≥2 cycles), NEXT, FETCH, LOAD, ARM = 8 cycles minimum.
- oStartProcessing and oDoneFeedback are never high in the same cycle, except in the stale-drain case.

## Structure
- Shared package `ga_pkg`, containing:
  - state enum;
  - NUM_CHROM_OUTPUTS=8;
  - FITNESS_W=32;
  - CHROM_BITS=992;
  - FITNESS_MAX=32'hFFFFFFFF.
- One sub-module, `error_sum_reducer`: 8×32 → 32 saturating adder tree, combinational, registered by the SUM state.

## Test plan
- POP_SIZE=4, processor model returns sums totalling {7,3,3,9} → four writes at addr 0..3 with those values; oBestIndex=1, oBestFitness=3; oGenerationDone once; oEvalCount=4.
- iStopOnPerfect=1, fitness at index 2 is 0 → exactly 3 writes; oPerfectFound=1; done pulse after index 2's ACK.
- iErrorSums all 32'hFFFFFFFF → oFitnessData=32'hFFFFFFFF; best unchanged (not strictly less); oBestIndex=0.
- Processor holds iProcReady=0 for 50 cycles → oStartProcessing stays high and the state stays ARM; transition occurs in the first ready cycle.
- Assert iReset_n=0 during WAIT_DONE with the processor model then reaching DONE; restart → ARM pulses oDoneFeedback, processor returns to ready, generation completes with 4 correct writes.
- iStartGeneration pulsed while busy → no effect on index, counts or writes.
